// File: rtl/rv_fetch_stage.sv
// rv_fetch_stage: RV32I instruction fetch stage and IF/ID pipeline register.
// Owns the fetch PC, drives a 1-cycle-latency synchronous instruction memory,
// and keeps a copy of the instruction in ID while the pipeline is stalled.
module rv_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_stall,
  input  logic        i_if_redirect,
  input  logic [31:0] i_if_redirect_pc,
  output logic [31:0] o_if_imem_addr,
  output logic        o_if_imem_re,
  input  logic [31:0] i_if_imem_rdata,
  output logic [31:0] o_if_pc_id,
  output logic [31:0] o_if_pc4_id,
  output logic [31:0] o_if_instr_id,
  output logic        o_if_valid_id,
  output logic        o_if_flush_idex
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HOLD   = 2'd1,
    S_BUBBLE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc_q;
  logic [XLEN-1:0]   r_pc_id;
  logic              r_valid_id;
  logic [XLEN-1:0]   r_hold_instr;
  logic              r_hold_vld;

  logic              w_imem_re;
  logic              w_flush;
  logic              w_capture;
  logic              w_do_redirect;
  logic              w_do_advance;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: stall holds, redirect inserts a bubble, otherwise run
  always_comb begin
    w_state_nxt = r_state;
    if (i_if_stall) begin
      w_state_nxt = S_HOLD;
    end else if (i_if_redirect) begin
      w_state_nxt = S_BUBBLE;
    end else begin
      w_state_nxt = S_RUN;
    end
  end

  // Control decode: memory enable, ID/EX flush, hold capture, PC update kind
  always_comb begin
    w_imem_re     = 1'b1;
    w_flush       = 1'b0;
    w_capture     = 1'b0;
    w_do_redirect = 1'b0;
    w_do_advance  = 1'b0;
    if (i_rst) begin
      w_imem_re = 1'b1;
    end else if (i_if_stall) begin
      w_imem_re = 1'b0;
      // Only the first stall cycle sees fresh read data worth keeping
      w_capture = (r_state != S_HOLD);
    end else if (i_if_redirect) begin
      w_flush       = 1'b1;
      w_do_redirect = 1'b1;
    end else begin
      w_do_advance = 1'b1;
    end
  end

  // Fetch PC and IF/ID register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc_q       <= RESET_PC;
      r_pc_id      <= '0;
      r_valid_id   <= 1'b0;
      r_hold_instr <= '0;
      r_hold_vld   <= 1'b0;
    end else if (i_if_stall) begin
      if (w_capture) begin
        r_hold_instr <= i_if_imem_rdata;
        r_hold_vld   <= 1'b1;
      end
    end else if (w_do_redirect) begin
      r_pc_q     <= i_if_redirect_pc & ALIGN_MASK;
      r_valid_id <= 1'b0;
      r_hold_vld <= 1'b0;
    end else if (w_do_advance) begin
      r_pc_id    <= r_pc_q;
      r_pc_q     <= r_pc_q + PC_STEP;
      r_valid_id <= 1'b1;
      r_hold_vld <= 1'b0;
    end
  end

  assign o_if_imem_addr  = r_pc_q;
  assign o_if_imem_re    = w_imem_re;
  assign o_if_pc_id      = r_pc_id;
  assign o_if_pc4_id     = r_pc_id + PC_STEP;
  assign o_if_valid_id   = r_valid_id;
  assign o_if_flush_idex = w_flush;
  // While held, memory output is stale; show the captured instruction instead
  assign o_if_instr_id   = !r_valid_id ? NOP_INSTR
                         : (r_hold_vld ? r_hold_instr : i_if_imem_rdata);

endmodule

// File: tb/tb_rv_fetch_stage.sv
// Directed bench for rv_fetch_stage. Instruction memory model returns addr+1
// one cycle after a read, and a poison word when the read enable is low.
module tb_rv_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id;
  logic [31:0] pc4_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic        flush;

  int checks;
  int failures;

  rv_fetch_stage dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_if_stall       (stall),
    .i_if_redirect    (redir),
    .i_if_redirect_pc (redir_pc),
    .o_if_imem_addr   (imem_addr),
    .o_if_imem_re     (imem_re),
    .i_if_imem_rdata  (imem_rdata),
    .o_if_pc_id       (pc_id),
    .o_if_pc4_id      (pc4_id),
    .o_if_instr_id    (instr_id),
    .o_if_valid_id    (valid_id),
    .o_if_flush_idex  (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address a is a+1
  always @(posedge clk) begin
    imem_rdata <= imem_re ? (imem_addr + 32'd1) : POISON;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".valid"}, 32'(valid_id), 32'(v));
    chk({tag, ".pc"}, pc_id, pc);
    chk({tag, ".pc4"}, pc4_id, pc + 32'd4);
    chk({tag, ".instr"}, instr_id, ins);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    stall = 1'b0;
    redir = 1'b0;
    redir_pc = '0;
    imem_rdata = '0;
    tick();
    tick();

    // Reset state; flush suppressed even with a redirect request
    chk("rst.valid", 32'(valid_id), 32'd0);
    chk("rst.instr", instr_id, NOP);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.pc_id", pc_id, 32'h0);
    chk("rst.re", 32'(imem_re), 32'd1);
    redir = 1'b1; redir_pc = 32'h40;
    #1 chk("rst.flush", 32'(flush), 32'd0);
    redir = 1'b0;

    // Scenario 1: sequential fetch
    rst = 1'b0;
    tick(); chk_id("s1.0", 1'b1, 32'h0, 32'h1);
    chk("s1.addr", imem_addr, 32'h4);
    tick(); chk_id("s1.4", 1'b1, 32'h4, 32'h5);
    tick(); chk_id("s1.8", 1'b1, 32'h8, 32'h9);

    // Scenario 2: three-cycle stall at pc_id=8
    stall = 1'b1;
    #1 chk("s2.re", 32'(imem_re), 32'd0);
    chk("s2.flush", 32'(flush), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_id("s2.hold", 1'b1, 32'h8, 32'h9);
      chk("s2.addr", imem_addr, 32'hC);
    end
    stall = 1'b0;
    #1 chk_id("s2.rel", 1'b1, 32'h8, 32'h9);
    chk("s2.rel_re", 32'(imem_re), 32'd1);
    tick(); chk_id("s2.12", 1'b1, 32'hC, 32'hD);
    tick(); chk_id("s2.16", 1'b1, 32'h10, 32'h11);

    // Scenario 3: redirect to 0x100
    redir = 1'b1; redir_pc = 32'h100;
    #1 chk("s3.flush", 32'(flush), 32'd1);
    tick(); redir = 1'b0;
    #1 chk("s3.bub_valid", 32'(valid_id), 32'd0);
    chk("s3.bub_instr", instr_id, NOP);
    chk("s3.bub_flush", 32'(flush), 32'd0);
    chk("s3.addr", imem_addr, 32'h100);
    tick(); chk_id("s3.tgt", 1'b1, 32'h100, 32'h101);
    tick(); chk_id("s3.next", 1'b1, 32'h104, 32'h105);

    // Scenario 4: stall with redirect -> redirect ignored until release
    stall = 1'b1; redir = 1'b1; redir_pc = 32'h200;
    #1 chk("s4.flush_st", 32'(flush), 32'd0);
    tick(); chk_id("s4.held", 1'b1, 32'h104, 32'h105);
    chk("s4.addr", imem_addr, 32'h108);
    tick(); chk_id("s4.held2", 1'b1, 32'h104, 32'h105);
    stall = 1'b0;
    #1 chk("s4.flush_rel", 32'(flush), 32'd1);
    tick(); redir = 1'b0;
    #1 chk("s4.bub_valid", 32'(valid_id), 32'd0);
    chk("s4.addr2", imem_addr, 32'h200);
    tick(); chk_id("s4.tgt", 1'b1, 32'h200, 32'h201);

    // Scenario 5: misaligned target and PC wrap
    redir = 1'b1; redir_pc = 32'h103;
    tick(); redir = 1'b0;
    #1 chk("s5.align", imem_addr, 32'h100);
    tick(); chk_id("s5.tgt", 1'b1, 32'h100, 32'h101);
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick(); redir = 1'b0;
    #1 chk("s5.top", imem_addr, 32'hFFFF_FFFC);
    tick(); chk_id("s5.last", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFD);
    chk("s5.wrap", imem_addr, 32'h0);
    tick(); chk_id("s5.zero", 1'b1, 32'h0, 32'h1);
    chk("s5.addr4", imem_addr, 32'h4);

    // Stall during the bubble keeps the bubble, then target arrives
    redir = 1'b1; redir_pc = 32'h300;
    tick(); redir = 1'b0; stall = 1'b1;
    tick(); chk_id("bs.bub", 1'b0, 32'h0, NOP);
    chk("bs.addr", imem_addr, 32'h300);
    stall = 1'b0;
    tick(); chk_id("bs.tgt", 1'b1, 32'h300, 32'h301);

    // Scenario 6: reset while holding
    stall = 1'b1;
    tick(); tick();
    chk_id("s6.hold", 1'b1, 32'h300, 32'h301);
    rst = 1'b1;
    tick();
    chk("s6.valid", 32'(valid_id), 32'd0);
    chk("s6.instr", instr_id, NOP);
    chk("s6.addr", imem_addr, 32'h0);
    chk("s6.re", 32'(imem_re), 32'd1);
    tick();
    rst = 1'b0; stall = 1'b0;
    tick(); chk_id("s6.0", 1'b1, 32'h0, 32'h1);
    tick(); chk_id("s6.4", 1'b1, 32'h4, 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
